vin_colorproc: RTL and testbench



---
 rtl/vin_colorproc.sv | 226 ++++++++++++++++++++++
 tb/tb_vin_colorproc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vin_colorproc.sv
// Input colour processor: turns PPC RGB pixels per beat into PPC 8-bit panel samples (mono / DES / Kaleido).
// Two-stage pipeline; syncs and valid are delayed alongside the pixel data.
module vin_colorproc #(
    parameter int PPC    = 2,
    parameter int IN_BPC = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic [PPC*24-1:0] in_color,
    input  logic              in_valid,
    output logic [PPC*8-1:0]  out_color,
    output logic              out_valid,
    output logic              out_vsync,
    output logic              out_hsync
);

    typedef enum logic [1:0] {
        MODE_MONO    = 2'd0,
        MODE_DES     = 2'd1,
        MODE_KALEIDO = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2,
        SEL_Y = 2'd3
    } sel_t;

    localparam logic [1:0] PPC_MOD3 = 2'(PPC % 3);
    localparam logic       PPC_ODD  = 1'(PPC % 2);

    // MSB replication of the top IN_BPC bits of an 8-bit channel field
    function automatic logic [7:0] expand(input logic [7:0] field);
        logic [7:0] e;
        for (int b = 0; b < 8; b++) begin
            e[7-b] = field[7 - (b % IN_BPC)];
        end
        return e;
    endfunction

    function automatic sel_t pick_sel(input mode_t mode, input logic [1:0] xp0,
                                      input logic xpar0, input logic lpar0, input int idx);
        logic [2:0] ph;
        logic       kbit;
        sel_t       s;
        ph = {1'b0, xp0} + 3'(idx % 3);
        if (ph >= 3'd3) begin
            ph = ph - 3'd3;
        end
        kbit = xpar0 ^ 1'(idx % 2);
        case (mode)
            MODE_DES:     s = sel_t'(ph[1:0]);
            MODE_KALEIDO: s = sel_t'({lpar0, kbit});
            default:      s = SEL_Y;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] sample_mux(input sel_t sel, input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b, input logic [15:0] pr,
                                              input logic [15:0] pg, input logic [15:0] pb);
        logic [15:0] sum;
        logic [7:0]  s;
        sum = pr + pg + pb;
        case (sel)
            SEL_R:   s = r;
            SEL_G:   s = g;
            SEL_B:   s = b;
            default: s = sum[15:8];
        endcase
        return s;
    endfunction

    mode_t       mode_q;
    logic        hs_last, vs_last;
    logic [11:0] line_idx;
    logic [1:0]  lp, xp;
    logic        xpar, first_line;

    logic        le, vs_rise;
    logic [11:0] n_line;
    logic [1:0]  n_lp, n_xp, xp_after;
    logic        n_xpar, n_first;
    logic [2:0]  xp_sum;

    logic        unused_in_bits;
    assign unused_in_bits = ^in_color;

    // Line-edge effects are resolved first so a beat on the edge cycle sees the new line's phase
    always_comb begin
        le      = !hs_last && in_hsync;
        vs_rise = !vs_last && in_vsync;
        n_line  = line_idx;
        n_lp    = lp;
        n_xp    = xp;
        n_xpar  = xpar;
        n_first = first_line;
        if (le) begin
            n_xpar = 1'b0;
            if (in_vsync) begin
                n_line  = '0;
                n_lp    = 2'd0;
                n_xp    = 2'd0;
                n_first = 1'b1;
            end else if (!first_line) begin
                n_line = line_idx + 12'd1;
                n_lp   = (lp == 2'd2) ? 2'd0 : lp + 2'd1;
                n_xp   = n_lp;
            end
        end
        xp_sum   = {1'b0, n_xp} + {1'b0, PPC_MOD3};
        xp_after = (xp_sum >= 3'd3) ? 2'(xp_sum - 3'd3) : xp_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= mode_t'(cfg_mode);
            hs_last    <= 1'b0;
            vs_last    <= 1'b0;
            line_idx   <= '0;
            lp         <= 2'd0;
            xp         <= 2'd0;
            xpar       <= 1'b0;
            first_line <= 1'b1;
        end else begin
            hs_last  <= in_hsync;
            vs_last  <= in_vsync;
            line_idx <= n_line;
            lp       <= n_lp;
            if (vs_rise) begin
                mode_q <= mode_t'(cfg_mode);
            end
            if (in_valid) begin
                xp         <= xp_after;
                xpar       <= n_xpar ^ PPC_ODD;
                first_line <= 1'b0;
            end else begin
                xp         <= n_xp;
                xpar       <= n_xpar;
                first_line <= n_first;
            end
        end
    end

    logic [7:0] r_c [PPC];
    logic [7:0] g_c [PPC];
    logic [7:0] b_c [PPC];
    sel_t       sel_c [PPC];

    always_comb begin
        for (int i = 0; i < PPC; i++) begin
            r_c[i]   = expand(in_color[(PPC-1-i)*24+16 +: 8]);
            g_c[i]   = expand(in_color[(PPC-1-i)*24+8 +: 8]);
            b_c[i]   = expand(in_color[(PPC-1-i)*24 +: 8]);
            sel_c[i] = pick_sel(mode_q, n_xp, n_xpar, n_line[0], i);
        end
    end

    logic [7:0]  r1 [PPC];
    logic [7:0]  g1 [PPC];
    logic [7:0]  b1 [PPC];
    logic [15:0] pr1 [PPC];
    logic [15:0] pg1 [PPC];
    logic [15:0] pb1 [PPC];
    sel_t        sel1 [PPC];
    logic        v1, vs1, hs1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            vs1 <= 1'b0;
            hs1 <= 1'b0;
            for (int i = 0; i < PPC; i++) begin
                r1[i]   <= '0;
                g1[i]   <= '0;
                b1[i]   <= '0;
                pr1[i]  <= '0;
                pg1[i]  <= '0;
                pb1[i]  <= '0;
                sel1[i] <= SEL_R;
            end
        end else begin
            v1  <= in_valid;
            vs1 <= in_vsync;
            hs1 <= in_hsync;
            for (int i = 0; i < PPC; i++) begin
                r1[i]   <= r_c[i];
                g1[i]   <= g_c[i];
                b1[i]   <= b_c[i];
                pr1[i]  <= 16'd77  * {8'd0, r_c[i]};
                pg1[i]  <= 16'd150 * {8'd0, g_c[i]};
                pb1[i]  <= 16'd29  * {8'd0, b_c[i]};
                sel1[i] <= sel_c[i];
            end
        end
    end

    logic [PPC*8-1:0] samp_vec;

    always_comb begin
        samp_vec = '0;
        for (int i = 0; i < PPC; i++) begin
            samp_vec[(PPC-1-i)*8 +: 8] = sample_mux(sel1[i], r1[i], g1[i], b1[i], pr1[i], pg1[i], pb1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_color <= '0;
            out_valid <= 1'b0;
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
        end else begin
            out_color <= samp_vec;
            out_valid <= v1;
            out_vsync <= vs1;
            out_hsync <= hs1;
        end
    end

endmodule

// File: tb/tb_vin_colorproc.sv
// Directed self-checking bench for vin_colorproc (PPC=2, IN_BPC=6) with hand-computed samples.
module tb_vin_colorproc;

    localparam int PPC    = 2;
    localparam int IN_BPC = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cfg_mode;
    logic              in_vsync, in_hsync, in_valid;
    logic [PPC*24-1:0] in_color;
    logic [PPC*8-1:0]  out_color;
    logic              out_valid, out_vsync, out_hsync;

    int check_count = 0;
    int error_count = 0;

    logic        prev_valid, prev_vs, prev_hs, prev_chk;
    logic [15:0] prev_color;
    string       prev_tag;

    logic [PPC*24-1:0] mid, white_black, red_green;

    vin_colorproc #(.PPC(PPC), .IN_BPC(IN_BPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .in_vsync  (in_vsync),
        .in_hsync  (in_hsync),
        .in_color  (in_color),
        .in_valid  (in_valid),
        .out_color (out_color),
        .out_valid (out_valid),
        .out_vsync (out_vsync),
        .out_hsync (out_hsync)
    );

    always #5 clk = ~clk;

    // Low two bits of each field are deliberately non-zero; only the top 6 bits may matter
    function automatic logic [23:0] px(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        return {r, 2'b10, g, 2'b10, b, 2'b10};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one beat, then check the outputs produced by the previous beat (2-cycle latency)
    task automatic applyStimulus(input string tag, input logic r, input logic vs, input logic hs,
                                 input logic v, input logic [PPC*24-1:0] color,
                                 input logic [15:0] exp_color, input logic chk);
        rst      = r;
        in_vsync = vs;
        in_hsync = hs;
        in_valid = v;
        in_color = color;
        @(posedge clk);
        #1;
        if (r) begin
            checkOutput({tag, ".rst_valid"}, 16'(out_valid), 16'd0);
            checkOutput({tag, ".rst_vsync"}, 16'(out_vsync), 16'd0);
            checkOutput({tag, ".rst_hsync"}, 16'(out_hsync), 16'd0);
            checkOutput({tag, ".rst_color"}, out_color, 16'h0000);
            prev_valid = 1'b0;
            prev_vs    = 1'b0;
            prev_hs    = 1'b0;
            prev_chk   = 1'b1;
            prev_color = 16'h0000;
            prev_tag   = {tag, ".flush"};
        end else begin
            checkOutput({prev_tag, ".valid"}, 16'(out_valid), 16'(prev_valid));
            checkOutput({prev_tag, ".vsync"}, 16'(out_vsync), 16'(prev_vs));
            checkOutput({prev_tag, ".hsync"}, 16'(out_hsync), 16'(prev_hs));
            if (prev_chk) begin
                checkOutput({prev_tag, ".color"}, out_color, prev_color);
            end
            prev_valid = v;
            prev_vs    = vs;
            prev_hs    = hs;
            prev_chk   = chk;
            prev_color = exp_color;
            prev_tag   = tag;
        end
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 1'b0);
    endtask

    task automatic beat(input string tag, input logic [PPC*24-1:0] color, input logic [15:0] exp_color);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b1, color, exp_color, 1'b1);
    endtask

    task automatic lineEdge(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h0, 1'b0);
    endtask

    task automatic frameStart(input string tag, input logic [1:0] mode);
        cfg_mode = mode;
        applyStimulus({tag, ".vrise"}, 1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0, 1'b0);
        applyStimulus({tag, ".vle"},   1'b0, 1'b1, 1'b1, 1'b0, '0, 16'h0, 1'b0);
        applyStimulus({tag, ".vfall"}, 1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 1'b0);
    endtask

    initial begin
        // expanded (0x10,0x20,0x30) = (0x41,0x82,0xC3); luma = (5005+19500+5655)>>8 = 0x75
        mid         = {px(6'h10, 6'h20, 6'h30), px(6'h10, 6'h20, 6'h30)};
        white_black = {px(6'h3F, 6'h3F, 6'h3F), px(6'h00, 6'h00, 6'h00)};
        red_green   = {px(6'h3F, 6'h00, 6'h00), px(6'h00, 6'h3F, 6'h00)};
        cfg_mode    = 2'd0;

        applyStimulus("reset0", 1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h0, 1'b0);
        applyStimulus("reset1", 1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h0, 1'b0);

        beat("mono_wb", white_black, 16'hFF00);
        idle("mono_gap0");
        idle("mono_gap1");
        beat("mono_rg", red_green, 16'h4C95);
        beat("mono_mid", mid, 16'h7575);
        idle("mono_gap2");

        cfg_mode = 2'd1;
        beat("mode_held", mid, 16'h7575);
        idle("mode_gap");

        frameStart("des_frame", 2'd1);
        lineEdge("des_blank0");
        idle("des_blank0_rest");
        lineEdge("des_blank1");
        idle("des_blank1_rest");

        lineEdge("des_l0_le");
        beat("des_l0_b0", mid, 16'h4182);
        beat("des_l0_b1", mid, 16'hC341);
        idle("des_l0_hole");
        beat("des_l0_b2", mid, 16'h82C3);

        lineEdge("des_l1_le");
        beat("des_l1_b0", mid, 16'h82C3);
        beat("des_l1_b1", mid, 16'h4182);
        beat("des_l1_b2", mid, 16'hC341);

        lineEdge("des_l2_le");
        beat("des_l2_b0", mid, 16'hC341);
        beat("des_l2_b1", mid, 16'h82C3);
        beat("des_l2_b2", mid, 16'h4182);

        applyStimulus("des_l3_le_beat", 1'b0, 1'b0, 1'b1, 1'b1, mid, 16'h4182, 1'b1);
        beat("des_l3_b1", mid, 16'hC341);
        idle("des_end");

        frameStart("kal_frame", 2'd2);
        lineEdge("kal_l0_le");
        beat("kal_l0_b0", mid, 16'h4182);
        beat("kal_l0_b1", mid, 16'h4182);
        lineEdge("kal_l1_le");
        beat("kal_l1_b0", mid, 16'hC375);
        beat("kal_l1_b1", mid, 16'hC375);

        cfg_mode = 2'd1;
        applyStimulus("midline_rst", 1'b1, 1'b0, 1'b0, 1'b1, mid, 16'h0, 1'b0);
        beat("post_rst_b0", mid, 16'h4182);
        beat("post_rst_b1", mid, 16'hC341);
        lineEdge("post_rst_le");
        beat("post_rst_l1", mid, 16'h82C3);
        idle("post_rst_end");

        frameStart("rsvd_frame", 2'd3);
        lineEdge("rsvd_le");
        beat("rsvd_rg", red_green, 16'h4C95);
        idle("rsvd_gap0");
        idle("rsvd_gap1");

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
